// File: rtl/pair_stream_pkg.sv
// Shared types and helpers for the complement-coded bit-pair receive path.
// Used by pair_stream_deserializer and pair_bit_checker.
package pair_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } deser_state_e;

  localparam int MAX_WIDTH = 32;

  function automatic logic pair_ok(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/pair_bit_checker.sv
// Flags a bit pair whose two halves are not complements of each other.
// Purely combinational.
module pair_bit_checker
  import pair_stream_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic mismatch
);

  assign mismatch = ~pair_ok(a, b);

endmodule

// File: rtl/pair_stream_deserializer.sv
// Packs complement-coded bit pairs (LSB first) into WIDTH-bit words.
// Define PAIR_STREAM_DESER_PARITY_EN to expect a trailing even-parity beat.
module pair_stream_deserializer
  import pair_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit_a,
  input  logic             in_bit_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

`ifdef PAIR_STREAM_DESER_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  deser_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sreg;
  logic err;
  logic mismatch;
  logic accept;
  logic last;
  logic beat_err;
  logic shift_en;

  pair_bit_checker u_chk (
    .a       (in_bit_a),
    .b       (in_bit_b),
    .mismatch(mismatch)
  );

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST);

`ifdef PAIR_STREAM_DESER_PARITY_EN
  // The parity beat is checked against the already-complete word.
  assign beat_err = mismatch | (last & (^sreg ^ in_bit_a));
  assign shift_en = !last;
`else
  assign beat_err = mismatch;
  assign shift_en = 1'b1;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = last ? HOLD : SHIFT;
      SHIFT:   if (accept && last) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == HOLD && out_ready) begin
        cnt  <= '0;
        sreg <= '0;
        err  <= 1'b0;
      end else if (accept) begin
        // Holding cnt on the final beat keeps it inside its range.
        if (!last) cnt <= cnt + CW'(1);
        if (shift_en) sreg <= {in_bit_a, sreg[WIDTH-1:1]};
        if (beat_err) err <= 1'b1;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state == SHIFT);
  assign out_data  = sreg;
  assign out_err   = err;

endmodule

// File: tb/tb_pair_stream_deserializer.sv
// Scoreboard bench for pair_stream_deserializer (WIDTH=8).
// Honours PAIR_STREAM_DESER_PARITY_EN when defined.
module tb_pair_stream_deserializer;

  localparam int W = 8;
`ifdef PAIR_STREAM_DESER_PARITY_EN
  localparam int BEATS = W + 1;
`else
  localparam int BEATS = W;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_bit_a = 1'b0;
  logic         in_bit_b = 1'b1;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         busy;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int hs = 0;
  int stalls = 0;
  int mode = 0;

  pair_stream_deserializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit_a (in_bit_a),
    .in_bit_b (in_bit_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 = always, 1 = random, 2 = stalled.
  always begin
    @(posedge clk);
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word act=%h exp=none", out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word_data", 32'(out_data), 32'(e.d));
        chk("word_err", 32'(out_err), 32'(e.e));
      end
      hs++;
    end
  end

  // Model: word is the data bits, error if any pair is not complementary
  // or the parity beat is wrong; nb < BEATS sends a fragment with no output.
  task automatic send(input logic [W-1:0] d, input logic [8:0] badm,
                      input bit pflip, input int gap, input int nb);
    if (nb == BEATS) q.push_back('{d, (|badm[BEATS-1:0]) | pflip});
    for (int i = 0; i < nb; i++) begin
      logic a;
      bit acc;
      int n;
      a = (i < W) ? d[i] : (^d ^ pflip);
      while (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_bit_a = a;
      in_bit_b = badm[i] ? a : ~a;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        if (!acc) stalls++;
        @(posedge clk);
        #1;
        n++;
        if (!acc && n > 300) begin
          total++;
          bad++;
          $display("FAIL beat_accept_timeout act=0 exp=1");
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int h0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Clean word and output latency
    send(8'hA5, 9'h0, 1'b0, 0, BEATS);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;

    // Mismatched pair 3, then a clean word
    send(8'h3C, 9'h008, 1'b0, 0, BEATS);
    send(8'h5A, 9'h0, 1'b0, 0, BEATS);

    // Downstream stall while holding
    mode = 2;
    send(8'hFF, 9'h0, 1'b0, 0, BEATS);
    h0 = hs;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_data", 32'(out_data), 32'hFF);
    end
    mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_one_handshake", 32'(hs), 32'(h0 + 1));

    // Reset mid-word discards the fragment
    h0 = hs;
    send(8'h0F, 9'h0, 1'b0, 0, 4);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    send(8'h81, 9'h0, 1'b0, 0, BEATS);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_one_word", 32'(hs), 32'(h0 + 1));

    // Back-to-back words with in_valid held high
    h0 = hs;
    stalls = 0;
    send(8'h12, 9'h0, 1'b0, 0, BEATS);
    send(8'h34, 9'h0, 1'b0, 0, BEATS);
    chk("b2b_bubble", 32'(stalls), 32'd1);
    @(negedge clk);
    chk("b2b_hold_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(in_ready), 32'd1);
    chk("b2b_words", 32'(hs), 32'(h0 + 2));
    @(posedge clk);
    #1;

`ifdef PAIR_STREAM_DESER_PARITY_EN
    send(8'hA5, 9'h0, 1'b0, 0, BEATS);
    send(8'hA5, 9'h0, 1'b1, 0, BEATS);
`endif

    // Randomized traffic with random backpressure
    mode = 1;
    for (int k = 0; k < 40; k++) begin
      logic [8:0] bm;
      bit pf;
      bm = 9'h0;
      if ($urandom_range(4) == 0) bm[$urandom_range(BEATS - 1)] = 1'b1;
      pf = 1'b0;
`ifdef PAIR_STREAM_DESER_PARITY_EN
      pf = ($urandom_range(5) == 0);
`endif
      send(8'($urandom), bm, pf, 30, BEATS);
    end
    mode = 0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
